clock_div_channel_array: RTL
============================

Name: clock_div_channel_array

Overview:
- Parametrised, multi-channel divided-clock generator; successor to the fixed 8-output distributor.
- Every channel runs in the ref_clk domain and produces a divided clock waveform plus a one-cycle enable strobe.
- Adds per-channel start/stop FSM, glitch-free ratio change at period boundaries, and sync-pulse phase alignment across channels.
- Adds stability qualification and sticky config-error reporting.
- Feeds downstream clock-enable consumers (data path, config, timing, I3C) in the RCD.

Parameters:
- NUM_CH, 8, number of independent channels.
- DIV_W, 8, width of each division ratio.
- DEFAULT_RATIO, 2, ratio loaded at reset; must be 1..2^DIV_W-1.
- STABLE_PERIODS, 4, completed periods after the last ratio apply before ch_stable asserts; must be >= 1.
- ALIGN_START, 1, 1 = a channel leaving OFF waits for sync_pulse; 0 = it starts unconditionally.

Ports:
- ref_clk  in  1  sole clock.
- rst  in  1  asynchronous active-high reset.
- cfg_ch_en  in  NUM_CH  per-channel run request (level).
- cfg_div_ratio  in  NUM_CH*DIV_W  ratio for channel i in bits [i*DIV_W +: DIV_W].
- cfg_ratio_load  in  NUM_CH  one-cycle strobe that captures that channel's cfg_div_ratio.
- sync_pulse  in  1  global phase-alignment strobe.
- err_clear  in  1  clears ratio_err.
- clk_out  out  NUM_CH  divided clock waveform.
- clk_en  out  NUM_CH  one-cycle strobe at each divided-clock period start.
- ch_active  out  NUM_CH  channel in RUN or DRAIN.
- ch_stable  out  NUM_CH  channel qualified stable.
- ratio_err  out  NUM_CH  sticky, set on an illegal ratio load.

Behaviour:
- Reset (async, rst=1):
  - All channels enter OFF; active ratio R = pending ratio = DEFAULT_RATIO; counter c = 0; stable count = 0.
  - All outputs are 0.
- Per channel, counter c runs 0..R-1 in RUN/DRAIN. All outputs are registered and aligned with c:
  - clk_out = (c < (R+1)>>1), i.e. high for ceil(R/2) cycles.
  - clk_en = (c == 0).
  - R = 1: clk_out and clk_en are constant 1 while running.
- FSM states: OFF, START, RUN, DRAIN.
  - OFF: outputs 0. cfg_ch_en=1 sampled moves to START.
  - START: outputs 0.
    - ALIGN_START=0: stays one cycle, then RUN with c=0.
    - ALIGN_START=1: held until sync_pulse is sampled, then RUN with c=0 the next cycle.
    - cfg_ch_en=0 while in START returns to OFF.
  - RUN: counts; c wraps R-1 to 0. cfg_ch_en=0 sampled moves to DRAIN.
  - DRAIN: keeps counting and driving outputs until the cycle with c=R-1, then OFF (clk_out 0 next cycle). No truncated period is ever produced. cfg_ch_en=1 sampled in DRAIN returns to RUN with the count uninterrupted.
- Latency with ALIGN_START=0: cfg_ch_en sampled high at edge t gives START at t+1 and first clk_en=1 at t+2.
- Ratio load (cfg_ratio_load[i]=1):
  - cfg_div_ratio=0 is rejected: pending is unchanged and ratio_err[i] is set.
  - Otherwise the value goes into pending.
  - Pending becomes R only at a period boundary (the cycle c returns to 0), or immediately if the channel is OFF/START.
  - Several loads before a boundary: the last legal one wins.
  - Any apply that changes R clears the stable count.
- sync_pulse with the channel in RUN/DRAIN: c forced to 0 next cycle (clk_en=1, clk_out=1). This also counts as a boundary, so a pending ratio applies there. sync_pulse in OFF is ignored.
- Stability:
  - Stable count increments on each wrap of c to 0 (natural or sync-forced) and saturates at STABLE_PERIODS.
  - Cleared on ratio apply and on entering OFF.
  - ch_stable = (state==RUN) && (count==STABLE_PERIODS).
- ratio_err: set and err_clear in the same cycle, set wins. err_clear acts on all channels.
- ch_active = 1 in RUN or DRAIN.
- Counter, stable count and ratio arithmetic use DIV_W-bit unsigned values. Comparisons must use no truncation (compute R+1 in DIV_W+1 bits).

Test Plan:
- Reset, ALIGN_START=0, ch0 ratio 4, enable at t -> first clk_en at t+2; clk_out pattern 1,1,0,0 repeating; clk_en every 4 cycles; ch_stable after 4 wraps.
- Ratio 5 on ch1 -> clk_out high 3 / low 2. Load ratio 3 at c=1 -> current 5-cycle period completes, then 3-cycle periods; ch_stable drops at apply and reasserts 4 periods later.
- ALIGN_START=1, enable ch0 (R=4) and ch2 (R=6) at different cycles, then pulse sync_pulse -> both clk_en=1 in the same cycle after the pulse; a later mid-period sync forces both back to c=0 together.
- Deassert cfg_ch_en at c=1 of R=8 -> clk_out/clk_en continue through c=7, then 0 and ch_active=0. Re-enable during DRAIN -> count continues with no gap.
- Load ratio 0 on ch3 -> ratio_err[3]=1 and division unchanged. err_clear together with a new illegal load -> ratio_err stays 1. err_clear alone -> 0.
- Assert rst mid-period on all channels -> all outputs 0 immediately; after release every R = DEFAULT_RATIO (2); enabling yields clk_out 1,0 repeating.

Source files
------------

// File: rtl/clock_div_channel_array.sv
// Multi-channel divided-clock generator in the ref_clk domain: per-channel start/stop
// sequencing, period-boundary ratio changes, sync-pulse alignment and stability flags.
module clock_div_channel_array #(
    parameter int NUM_CH         = 8,
    parameter int DIV_W          = 8,
    parameter int DEFAULT_RATIO  = 2,
    parameter int STABLE_PERIODS = 4,
    parameter bit ALIGN_START    = 1'b1
) (
    input  logic                    ref_clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       cfg_ch_en_i,
    input  logic [NUM_CH*DIV_W-1:0] cfg_div_ratio_i,
    input  logic [NUM_CH-1:0]       cfg_ratio_load_i,
    input  logic                    sync_pulse_i,
    input  logic                    err_clear_i,
    output logic [NUM_CH-1:0]       clk_out_o,
    output logic [NUM_CH-1:0]       clk_en_o,
    output logic [NUM_CH-1:0]       ch_active_o,
    output logic [NUM_CH-1:0]       ch_stable_o,
    output logic [NUM_CH-1:0]       ratio_err_o
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [DIV_W-1:0] RATIO_RST = DIV_W'(DEFAULT_RATIO);
    localparam logic [DIV_W-1:0] STAB_MAX  = DIV_W'(STABLE_PERIODS);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
    localparam logic [DIV_W:0]   ONE_W     = (DIV_W+1)'(1);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_e           state_q, state_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] ratio_q, ratio_d;
        logic [DIV_W-1:0] pend_q, pend_d;
        logic [DIV_W-1:0] stab_q, stab_d;
        logic             clk_out_q, clk_out_d;
        logic             clk_en_q, clk_en_d;
        logic             stable_q, stable_d;
        logic             err_q, err_d;

        logic [DIV_W-1:0] ld_val;
        logic             ld_ok;
        logic             ld_bad;
        logic             running;
        logic             active_d;
        logic             at_last;
        logic             wrap;
        logic [DIV_W:0]   half_d;

        assign ld_val  = cfg_div_ratio_i[g*DIV_W +: DIV_W];
        assign ld_ok   = cfg_ratio_load_i[g] && (ld_val != '0);
        assign ld_bad  = cfg_ratio_load_i[g] && (ld_val == '0);
        assign running = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        assign at_last = (cnt_q == (ratio_q - ONE));
        // A period boundary is either the natural wrap or a sync-forced restart.
        assign wrap    = running && (at_last || sync_pulse_i);

        always_ff @(posedge ref_clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= ST_OFF;
            end else begin
                state_q <= state_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_OFF: begin
                    if (cfg_ch_en_i[g]) state_d = ST_START;
                end
                ST_START: begin
                    if (!cfg_ch_en_i[g])                  state_d = ST_OFF;
                    else if (!ALIGN_START || sync_pulse_i) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!cfg_ch_en_i[g]) state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (cfg_ch_en_i[g]) state_d = ST_RUN;
                    else if (at_last)   state_d = ST_OFF;
                end
                default: state_d = ST_OFF;
            endcase
        end

        always_comb begin
            pend_d   = ld_ok ? ld_val : pend_q;
            ratio_d  = ratio_q;
            cnt_d    = '0;
            stab_d   = stab_q;
            active_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);

            // Idle channels track the pending ratio; running ones only switch at a boundary.
            if (!running || wrap) ratio_d = pend_d;

            if (active_d && running && !wrap) cnt_d = cnt_q + ONE;

            if (wrap && (stab_q != STAB_MAX)) stab_d = stab_q + ONE;
            if ((ratio_d != ratio_q) || (state_d == ST_OFF)) stab_d = '0;

            err_d     = ld_bad | (err_q & ~err_clear_i);
            half_d    = ({1'b0, ratio_d} + ONE_W) >> 1;
            clk_out_d = active_d && ({1'b0, cnt_d} < half_d);
            clk_en_d  = active_d && (cnt_d == '0);
            stable_d  = (state_d == ST_RUN) && (stab_d == STAB_MAX);
        end

        always_ff @(posedge ref_clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q     <= '0;
                ratio_q   <= RATIO_RST;
                pend_q    <= RATIO_RST;
                stab_q    <= '0;
                clk_out_q <= 1'b0;
                clk_en_q  <= 1'b0;
                stable_q  <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                ratio_q   <= ratio_d;
                pend_q    <= pend_d;
                stab_q    <= stab_d;
                clk_out_q <= clk_out_d;
                clk_en_q  <= clk_en_d;
                stable_q  <= stable_d;
                err_q     <= err_d;
            end
        end

        assign clk_out_o[g]   = clk_out_q;
        assign clk_en_o[g]    = clk_en_q;
        assign ch_active_o[g] = running;
        assign ch_stable_o[g] = stable_q;
        assign ratio_err_o[g] = err_q;
    end

endmodule
